dsp_chain_result_collector: RTL

Terminal stage for a cascaded integer sum-of-products DSP chain. It consumes the 37-bit result of the last chain stage, using a tag delay line matched to the chain's pipeline latency to know which cycles carry valid results. It accumulates multi-beat dot products longer than one chain pass into a wide accumulator and buffers completed sums in a small FIFO. Results leave on a valid/ready stream, and the block returns credit-based backpressure to the operand issuer.

---
 rtl/dsp_chain_result_collector.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dsp_chain_result_collector.sv
// Terminal collector for a cascaded sum-of-products chain.
// A {valid,last} tag delay line matched to the chain latency marks the
// cycles where chain_result_i carries a real result. Multi-beat dot products
// are summed into a wide accumulator. Finished sums go into a small FIFO and
// leave on a valid/ready stream. Credit backpressure goes back to the issuer.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   issue_valid_i   beat presented to the chain this cycle
//   issue_last_i    beat closes its dot product (qualified by issue_valid_i)
//   issue_ready_o   collector accepts a beat this cycle
//   chain_result_i  signed 37-bit result from the last chain stage
//   out_valid_o     FIFO head valid
//   out_ready_i     downstream takes the head
//   out_data_o      signed completed dot product
//   out_beats_o     beats summed into out_data_o, saturating at 255
//   out_ovf_o       signed overflow seen while forming out_data_o
module dsp_chain_result_collector #(
  parameter int unsigned CHAIN_LAT  = 4,
  parameter int unsigned ACC_W      = 48,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid_i,
  input  logic             issue_last_i,
  output logic             issue_ready_o,
  input  logic [36:0]      chain_result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o,
  output logic [7:0]       out_beats_o,
  output logic             out_ovf_o
);

  localparam int unsigned RES_W     = 37;
  localparam int unsigned BEAT_W    = 8;
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned TAG_CNT_W = $clog2(CHAIN_LAT + 1);
  localparam int unsigned CRD_W     = ((CNT_W > TAG_CNT_W) ? CNT_W : TAG_CNT_W) + 1;

  // Tag delay line
  logic [CHAIN_LAT-1:0] tag_v_q, tag_v_d;
  logic [CHAIN_LAT-1:0] tag_l_q, tag_l_d;
  logic [TAG_CNT_W-1:0] last_cnt_d;

  // Accumulator
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic              ovf_acc_q, ovf_acc_d;

  // FIFO
  logic [ACC_W-1:0]  mem_data_q  [FIFO_DEPTH];
  logic [BEAT_W-1:0] mem_beats_q [FIFO_DEPTH];
  logic              mem_ovf_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              issue_ready_q, issue_ready_d;

  logic              accept;
  logic              res_fire;
  logic              res_last;
  logic              push;
  logic              pop;
  logic [ACC_W-1:0]  res_ext;
  logic [ACC_W-1:0]  sum;
  logic              ovf_this;
  logic [BEAT_W-1:0] beats_inc;

  // Shift tags; count last-tags still in flight after this edge.
  always_comb begin
    accept     = issue_valid_i & issue_ready_q;
    tag_v_d    = '0;
    tag_l_d    = '0;
    last_cnt_d = '0;
    tag_v_d[0] = accept;
    tag_l_d[0] = accept & issue_last_i;
    for (int unsigned i = 1; i < CHAIN_LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_l_d[i] = tag_l_q[i-1];
    end
    for (int unsigned i = 0; i < CHAIN_LAT; i++) begin
      last_cnt_d = last_cnt_d + TAG_CNT_W'(tag_l_d[i]);
    end
  end

  // Accumulate qualified results, push completed sums, track FIFO and credit.
  always_comb begin
    res_fire   = tag_v_q[CHAIN_LAT-1];
    res_last   = tag_l_q[CHAIN_LAT-1];
    res_ext    = {{(ACC_W-RES_W){chain_result_i[RES_W-1]}}, chain_result_i};
    sum        = acc_q + res_ext;
    // Overflow: operands agree in sign but the sum does not.
    ovf_this   = (acc_q[ACC_W-1] == res_ext[ACC_W-1]) & (sum[ACC_W-1] != acc_q[ACC_W-1]);
    beats_inc  = (beat_cnt_q == {BEAT_W{1'b1}}) ? beat_cnt_q : beat_cnt_q + BEAT_W'(1);
    push       = res_fire & res_last;
    pop        = out_valid_q & out_ready_i;

    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    ovf_acc_d  = ovf_acc_q;
    if (res_fire) begin
      if (res_last) begin
        acc_d      = '0;
        beat_cnt_d = '0;
        ovf_acc_d  = 1'b0;
      end else begin
        acc_d      = sum;
        beat_cnt_d = beats_inc;
        ovf_acc_d  = ovf_acc_q | ovf_this;
      end
    end

    fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    out_valid_d   = (fifo_cnt_d != '0);
    // Every last-tag in flight reserves a FIFO slot, so a push never overflows.
    issue_ready_d = (CRD_W'(fifo_cnt_d) + CRD_W'(last_cnt_d)) < CRD_W'(FIFO_DEPTH);
  end

  // Control and accumulator state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q       <= '0;
      tag_l_q       <= '0;
      acc_q         <= '0;
      beat_cnt_q    <= '0;
      ovf_acc_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      out_valid_q   <= 1'b0;
      issue_ready_q <= 1'b1;
    end else begin
      tag_v_q       <= tag_v_d;
      tag_l_q       <= tag_l_d;
      acc_q         <= acc_d;
      beat_cnt_q    <= beat_cnt_d;
      ovf_acc_q     <= ovf_acc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      out_valid_q   <= out_valid_d;
      issue_ready_q <= issue_ready_d;
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i]  <= '0;
        mem_beats_q[i] <= '0;
        mem_ovf_q[i]   <= 1'b0;
      end
    end else if (push) begin
      mem_data_q[wr_ptr_q]  <= sum;
      mem_beats_q[wr_ptr_q] <= beats_inc;
      mem_ovf_q[wr_ptr_q]   <= ovf_acc_q | ovf_this;
    end
  end

  assign issue_ready_o = issue_ready_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = mem_data_q[rd_ptr_q];
  assign out_beats_o   = mem_beats_q[rd_ptr_q];
  assign out_ovf_o     = mem_ovf_q[rd_ptr_q];

endmodule
